// File: rtl/serial_to_parallel.sv
// Deserializer: gathers N beats from a valid/ready stream into one N-element word.
// An assembly buffer plus an output register lets the next group arrive while a word waits.
module serial_to_parallel #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out [0:N-1],
  output logic                  valid_out,
  input  logic                  ready_out
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  logic [DATA_WIDTH-1:0] asm_q [0:N-1];
  logic [DATA_WIDTH-1:0] asm_d [0:N-1];
  logic [DATA_WIDTH-1:0] out_q [0:N-1];
  logic [DATA_WIDTH-1:0] out_d [0:N-1];
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  asm_full_q, asm_full_d;
  logic                  out_valid_q, out_valid_d;
  logic                  accept, out_free, last_beat;

  // Registered state only, so ready_out never reaches ready_in combinationally.
  assign ready_in  = !asm_full_q && !rst;
  assign accept    = valid_in && ready_in;
  assign out_free  = !out_valid_q || ready_out;
  assign last_beat = (cnt_q == CntW'(N - 1));

  always_comb begin
    asm_d       = asm_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    asm_full_d  = asm_full_q;
    out_valid_d = out_valid_q;

    // Drain first; a word loading in the same cycle overrides it below.
    if (out_valid_q && ready_out) begin
      out_valid_d = 1'b0;
    end

    if (accept && !last_beat) begin
      for (int unsigned i = 0; i < N - 1; i++) begin
        if (cnt_q == CntW'(i)) begin
          asm_d[i] = data_in;
        end
      end
      cnt_d = cnt_q + CntW'(1);
    end else if (accept) begin
      cnt_d = '0;
      if (out_free) begin
        for (int unsigned i = 0; i < N - 1; i++) begin
          out_d[i] = asm_q[i];
        end
        out_d[N-1]  = data_in;
        out_valid_d = 1'b1;
      end else begin
        asm_d[N-1] = data_in;
        asm_full_d = 1'b1;
      end
    end else if (asm_full_q && out_free) begin
      out_d       = asm_q;
      out_valid_d = 1'b1;
      asm_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '{default: '0};
      out_q       <= '{default: '0};
      cnt_q       <= '0;
      asm_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      asm_full_q  <= asm_full_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = out_q;
  assign valid_out = out_valid_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel: N=4 and N=1 instances, DATA_WIDTH=8,
// directed scenarios followed by randomized traffic against a word-count model.
module tb_serial_to_parallel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       vin4 = 1'b0, rout4 = 1'b0, rin4, vout4;
  logic [7:0] din4 = 8'h00;
  logic [7:0] dout4 [0:3];

  logic       vin1 = 1'b0, rout1 = 1'b0, rin1, vout1;
  logic [7:0] din1 = 8'h00;
  logic [7:0] dout1 [0:0];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_to_parallel #(.DATA_WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .valid_in(vin4), .data_in(din4), .ready_in(rin4),
    .data_out(dout4), .valid_out(vout4), .ready_out(rout4)
  );

  serial_to_parallel #(.DATA_WIDTH(8), .N(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(vin1), .data_in(din1), .ready_in(rin1),
    .data_out(dout1), .valid_out(vout1), .ready_out(rout1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats are grouped in arrival order; pend counts complete words
  // the block still owes the consumer. At most two can be owed (output + assembly).
  logic [7:0]  grp4 [$];
  logic [31:0] exp4 [$];
  logic [7:0]  exp1 [$];
  int          pend4 = 0;
  int          pend1 = 0;

  always @(posedge clk) begin : model_b
    int done4, done1;
    done4 = 0;
    done1 = 0;
    if (rst) begin
      grp4.delete();
      exp4.delete();
      exp1.delete();
      pend4 <= 0;
      pend1 <= 0;
    end else begin
      if (vin4 && pend4 < 2) begin
        grp4.push_back(din4);
        if (grp4.size() == 4) begin
          exp4.push_back({grp4[3], grp4[2], grp4[1], grp4[0]});
          grp4.delete();
          done4 = 1;
        end
      end
      if (vin1 && pend1 < 2) begin
        exp1.push_back(din1);
        done1 = 1;
      end
      pend4 <= pend4 + done4 - ((pend4 > 0 && rout4) ? 1 : 0);
      pend1 <= pend1 + done1 - ((pend1 > 0 && rout1) ? 1 : 0);
    end
  end

  // Monitor: checks handshake signals every cycle and pops the scoreboard on each transfer.
  logic        hold4 = 1'b0, hold1 = 1'b0;
  logic [31:0] held4 = '0;
  logic [7:0]  held1 = '0;

  always @(negedge clk) begin : mon_b
    logic [31:0] act4;
    act4 = {dout4[3], dout4[2], dout4[1], dout4[0]};
    chk("ready_in4", rin4, !rst && pend4 < 2);
    chk("valid_out4", vout4, pend4 > 0);
    chk("ready_in1", rin1, !rst && pend1 < 2);
    chk("valid_out1", vout1, pend1 > 0);
    if (hold4) chk("stable4", act4, held4);
    if (hold1) chk("stable1", dout1[0], held1);
    if (vout4 && rout4) begin
      if (exp4.size() == 0) chk("word4_expected", exp4.size(), 1);
      else                  chk("word4", act4, exp4.pop_front());
    end
    if (vout1 && rout1) begin
      if (exp1.size() == 0) chk("word1_expected", exp1.size(), 1);
      else                  chk("word1", dout1[0], exp1.pop_front());
    end
    hold4 <= vout4 && !rout4 && !rst;
    held4 <= act4;
    hold1 <= vout1 && !rout1 && !rst;
    held1 <= dout1[0];
  end

  // Presents one beat and holds it until accepted or the cycle bound runs out.
  task automatic send(input int which, input logic [7:0] d, input int bound, output bit ok);
    ok = 1'b0;
    if (which == 4) begin vin4 = 1'b1; din4 = d; end
    else            begin vin1 = 1'b1; din1 = d; end
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((which == 4) ? rin4 : rin1) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    if (which == 4) vin4 = 1'b0;
    else            vin1 = 1'b0;
  endtask

  task automatic send_ok(input int which, input logic [7:0] d);
    bit ok;
    send(which, d, 10, ok);
    chk("accept", ok, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim_b
    bit ok;
    // Reset with a beat presented: it must be ignored.
    rst = 1'b1;
    vin4 = 1'b1; din4 = 8'hFF;
    vin1 = 1'b1; din1 = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("reset_data4", dout4[i], 8'h00);
    chk("reset_data1", dout1[0], 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0; vin4 = 1'b0; vin1 = 1'b0;
    idle(1);

    // Basic assembly.
    rout4 = 1'b1;
    send_ok(4, 8'h11); send_ok(4, 8'h22); send_ok(4, 8'h33); send_ok(4, 8'h44);
    idle(3);

    // Continuous stream.
    for (int b = 0; b < 16; b++) send_ok(4, 8'(b));
    idle(3);

    // Backpressure: one word in out, one in assembly, then 0x09 must stall.
    rout4 = 1'b0;
    for (int b = 1; b <= 8; b++) send_ok(4, 8'(b));
    send(4, 8'h09, 3, ok);
    chk("beat09_blocked", ok, 1'b0);
    @(posedge clk); #1;
    rout4 = 1'b1;
    @(posedge clk); #1;
    rout4 = 1'b0;
    for (int b = 9; b <= 12; b++) send_ok(4, 8'(b));
    idle(2);
    rout4 = 1'b1;
    idle(4);

    // Reset mid-group discards the partial group.
    send_ok(4, 8'hA1); send_ok(4, 8'hA2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int b = 1; b <= 4; b++) send_ok(4, 8'hB0 + 8'(b));
    idle(3);

    // N=1 with gaps.
    rout1 = 1'b1;
    send_ok(1, 8'h5A);
    idle(1);
    send_ok(1, 8'h5B);
    idle(3);

    // Randomized traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      vin4  = 1'($urandom_range(0, 1));
      din4  = 8'($urandom);
      rout4 = ($urandom_range(0, 3) != 0);
      vin1  = 1'($urandom_range(0, 1));
      din1  = 8'($urandom);
      rout1 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    // Drain and confirm nothing owed remains.
    vin4 = 1'b0; vin1 = 1'b0; rout4 = 1'b1; rout1 = 1'b1;
    idle(6);
    @(negedge clk);
    chk("drain4", exp4.size(), 0);
    chk("drain1", exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Deserializer that gathers N consecutive DATA_WIDTH-bit beats from a valid/ready stream and presents them as one N-element parallel word on a second valid/ready interface. It is the receive-side counterpart of parallel_to_serial: the first beat accepted lands in data_out[0] and the last in data_out[N-1], so parallel_to_serial → serial_to_parallel round-trips words unchanged. An internal assembly buffer plus a separate output register lets the next group keep arriving while a finished word waits for the consumer. There is no combinational path from ready_out to ready_in.

## Interface
- DATA_WIDTH, 32, width of one beat
- N, 2, beats per parallel word (N ≥ 1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  beat on data_in valid
- data_in  in  DATA_WIDTH  serial beat
- ready_in  out  1  block accepts a beat this cycle
- data_out  out  [DATA_WIDTH-1:0] x [0:N-1]  assembled word, index 0 = first beat
- valid_out  out  1  data_out holds a complete word
- ready_out  in  1  consumer takes data_out this cycle

## Operation
- Beat accepted when valid_in && ready_in.
- Assembly buffer asm[0:N-1] plus counter cnt.
  - cnt width is max(1, $clog2(N)); cnt ranges 0..N-1.
  - Flag asm_full marks a completed word held in asm.
- Output register out[0:N-1] drives data_out; out_valid drives valid_out.
- Output is "free" when !out_valid || ready_out.
- Accept with cnt < N-1:
  - asm[cnt] <= data_in; cnt <= cnt+1.
- Accept with cnt == N-1 (completing beat):
  - If output free: out[i] <= asm[i] for i < N-1, out[N-1] <= data_in; out_valid <= 1; cnt <= 0.
  - Else: asm[N-1] <= data_in; asm_full <= 1; cnt <= 0.
- asm_full && output free: out <= asm; out_valid <= 1; asm_full <= 0.
- ready_in = !asm_full && !rst. It depends on registered state only.
- out_valid && ready_out with no new word loading: out_valid <= 0. data_out keeps its last value.
- Simultaneous drain and load in the same cycle: the new word wins, so out_valid stays 1.
- N == 1: every accepted beat is a completing beat, so cnt is unused (held 0).
- Once valid_out rises, data_out is stable until the cycle after the handshake.

## Timing
- Reset values: valid_out 0, data_out all 0, cnt 0, asm all 0, asm_full 0.
- ready_in is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Mid-operation reset discards any partial group and any pending or held word. Beats presented while rst is high are ignored.
- Latency: valid_out rises the cycle after the completing beat is accepted, provided the output is free.
- Throughput: with ready_out held high, one word every N accepted beats and ready_in stays 1 continuously.
- Backpressure with ready_out low:
  - One full word is held in out and a second in asm.
  - ready_in drops the cycle after the second completing beat is accepted.
  - The cycle after ready_out completes the handshake, asm moves to out. ready_in returns to 1 that same cycle.
- No beat is ever dropped or duplicated. Word order is preserved.

## Test plan
- Reset, N=4, DATA_WIDTH=8:
  - Stimulus: hold rst for 2 cycles with valid_in=1, data_in=0xFF.
  - Response: ready_in=0, valid_out=0, data_out all 0 during reset; ready_in=1 the cycle after release.
- Basic assembly:
  - Stimulus: stream 0x11,0x22,0x33,0x44 back-to-back with ready_out=1.
  - Response: valid_out=1 for exactly one cycle, the cycle after 0x44; data_out = {0x11,0x22,0x33,0x44}.
- Continuous stream:
  - Stimulus: stream beats 0x00..0x0F with ready_out=1.
  - Response: 4 words {00..03},{04..07},{08..0B},{0C..0F}, one every 4 cycles; ready_in never 0.
- Backpressure:
  - Stimulus: ready_out=0 while streaming 0x01..0x0C.
  - Response: word {01..04} held in out, word {05..08} held in asm; ready_in=0 from the cycle after 0x08; 0x09 not accepted.
  - Stimulus: then raise ready_out for 1 cycle.
  - Response: {05..08} appears the next cycle; ready_in=1 again; no beat lost.
- Reset mid-group:
  - Stimulus: accept 0xA1,0xA2, pulse rst, then send 0xB1..0xB4.
  - Response: only {B1,B2,B3,B4} is emitted.
- N=1 and gapped input:
  - Stimulus: N=1 with valid_in toggling 1/0, sending 0x5A then 0x5B.
  - Response: data_out[0]=0x5A then 0x5B, each valid_out one cycle after acceptance; no output on idle cycles.
